// File: rtl/shift_arbiter.sv
// Two-port round-robin front end for a single 16-bit barrel shifter.
// One result register; backpressure freezes it and blocks both request ports.

module shift_arbiter_shifter (
  input  logic [15:0] i_data,
  input  logic [3:0]  i_cnt,
  input  logic [1:0]  i_op,
  output logic [15:0] o_data
);
  logic [31:0] w_dbl;

  // Rotate: the upper half of {x,x} << cnt is x rotated left by cnt.
  assign w_dbl = {i_data, i_data} << i_cnt;

  always_comb begin
    o_data = i_data;
    case (i_op)
      2'b00: o_data = w_dbl[31:16];
      2'b01: o_data = i_data << i_cnt;
      2'b10: o_data = $unsigned($signed(i_data) >>> i_cnt);
      2'b11: o_data = i_data >> i_cnt;
      default: o_data = i_data;
    endcase
  end
endmodule

module shift_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_in,
  input  logic [3:0]  req0_cnt,
  input  logic [1:0]  req0_op,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_in,
  input  logic [3:0]  req1_cnt,
  input  logic [1:0]  req1_op,
  output logic        req1_ready,
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic        res_src,
  input  logic        res_ready,
  output logic        busy
);
  localparam int NUM_PORTS = 2;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t r_state, w_state_nxt;
  logic        r_rr;
  logic [15:0] r_data;
  logic        r_src;

  logic [NUM_PORTS-1:0]       w_vld;
  logic [NUM_PORTS-1:0]       w_rdy;
  logic [NUM_PORTS-1:0][15:0] w_in;
  logic [NUM_PORTS-1:0][3:0]  w_cnt;
  logic [NUM_PORTS-1:0][1:0]  w_op;
  logic        w_gnt;
  logic        w_slot_free;
  logic        w_acc;
  logic [15:0] w_sh_out;

  assign w_vld = {req1_valid, req0_valid};
  assign w_in  = {req1_in,    req0_in};
  assign w_cnt = {req1_cnt,   req0_cnt};
  assign w_op  = {req1_op,    req0_op};

  // Lone requester wins; on contention rr decides. Idle defaults to port 0.
  assign w_gnt       = (&w_vld) ? r_rr : w_vld[1];
  assign w_slot_free = (r_state == EMPTY) || res_ready;

  for (genvar n = 0; n < NUM_PORTS; n++) begin : g_rdy
    assign w_rdy[n] = w_slot_free && (w_gnt == 1'(n)) && w_vld[n] && !rst;
  end

  assign w_acc      = |w_rdy;
  assign req0_ready = w_rdy[0];
  assign req1_ready = w_rdy[1];

  shift_arbiter_shifter u_shifter (
    .i_data (w_in[w_gnt]),
    .i_cnt  (w_cnt[w_gnt]),
    .i_op   (w_op[w_gnt]),
    .o_data (w_sh_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_acc) w_state_nxt = FULL;
      FULL:    if (!w_acc && res_ready) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Payload only moves on an accept, so consume and stall both hold it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= 16'h0000;
      r_src  <= 1'b0;
      r_rr   <= 1'b0;
    end else if (w_acc) begin
      r_data <= w_sh_out;
      r_src  <= w_gnt;
      r_rr   <= ~w_gnt;
    end
  end

  assign res_valid = (r_state == FULL);
  assign res_data  = r_data;
  assign res_src   = r_src;
  assign busy      = res_valid;
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench: expected results queued up front, a negedge monitor pops
// and compares each result as it is consumed.

module tb_shift_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_in, req1_in;
  logic [3:0]  req0_cnt, req1_cnt;
  logic [1:0]  req0_op, req1_op;
  logic        req0_ready, req1_ready;
  logic        res_valid, res_src, res_ready, busy;
  logic [15:0] res_data;

  typedef struct { logic src; logic [15:0] data; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shift_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_in(req0_in), .req0_cnt(req0_cnt),
    .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_in(req1_in), .req1_cnt(req1_cnt),
    .req1_op(req1_op), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_data(res_data), .res_src(res_src),
    .res_ready(res_ready), .busy(busy)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic src, input logic [15:0] data);
    exp_t e;
    e.src  = src;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic set0(input logic v, input logic [15:0] d, input logic [3:0] c, input logic [1:0] o);
    req0_valid = v; req0_in = d; req0_cnt = c; req0_op = o;
  endtask

  task automatic set1(input logic v, input logic [15:0] d, input logic [3:0] c, input logic [1:0] o);
    req1_valid = v; req1_in = d; req1_cnt = c; req1_op = o;
  endtask

  // Monitor: every consumed result must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("busy_eq_valid", 16'(busy), 16'(res_valid));
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_result", res_data, 16'hxxxx);
          end else begin
            e = exp_q.pop_front();
            chk("sb_src", 16'(res_src), 16'(e.src));
            chk("sb_data", res_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  // Port-1 op vectors: in=8421 with cnt 3 then cnt 0.
  logic [1:0]  vop  [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
  logic [3:0]  vcnt [8] = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0};
  logic [15:0] vexp [8] = '{16'h210C, 16'h2108, 16'hF084, 16'h1084,
                            16'h8421, 16'h8421, 16'h8421, 16'h8421};

  // Contention vectors: accepts alternate 0,1,0,1.
  logic [15:0] c_in  [4] = '{16'h0001, 16'h8000, 16'h0003, 16'h8000};
  logic [3:0]  c_cnt [4] = '{4'd1, 4'd1, 4'd2, 4'd2};
  logic [1:0]  c_op  [4] = '{2'b01, 2'b11, 2'b01, 2'b10};
  logic [15:0] c_exp [4] = '{16'h0002, 16'h4000, 16'h000C, 16'hE000};

  initial begin
    rst = 1'b1; res_ready = 1'b0;
    set0(1'b0, 16'h0, 4'd0, 2'b00);
    set1(1'b0, 16'h0, 4'd0, 2'b00);
    repeat (2) cyc();

    // Reset state, with a request present that must not be accepted.
    set0(1'b1, 16'h8001, 4'd1, 2'b00);
    @(negedge clk);
    chk("rst_req0_ready", 16'(req0_ready), 16'h0);
    chk("rst_res_valid", 16'(res_valid), 16'h0);
    chk("rst_res_data", res_data, 16'h0000);
    chk("rst_res_src", 16'(res_src), 16'h0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_req0_ready", 16'(req0_ready), 16'h1);
    cyc();
    set0(1'b0, 16'h0, 4'd0, 2'b00);
    @(negedge clk);
    chk("mid_res_valid", 16'(res_valid), 16'h1);
    chk("mid_res_data", res_data, 16'h0003);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 16'(res_valid), 16'h0);
    chk("async_rst_data", res_data, 16'h0000);
    cyc();
    rst = 1'b0;

    // First grant after reset is port 0, then port 1 runs alone.
    res_ready = 1'b1;
    push(1'b0, 16'h0F00);
    push(1'b1, 16'h1084);
    set0(1'b1, 16'h00F0, 4'd4, 2'b01);
    set1(1'b1, 16'h8421, 4'd3, 2'b11);
    @(negedge clk);
    chk("post_rst_r0", 16'(req0_ready), 16'h1);
    chk("post_rst_r1", 16'(req1_ready), 16'h0);
    cyc();
    set0(1'b0, 16'h0, 4'd0, 2'b00);
    @(negedge clk);
    chk("single_res_valid", 16'(res_valid), 16'h1);
    chk("single_res_data", res_data, 16'h0F00);
    chk("second_r1", 16'(req1_ready), 16'h1);
    cyc();
    set1(1'b0, 16'h0, 4'd0, 2'b00);
    repeat (2) cyc();

    // Op coverage on port 1, back to back.
    for (int i = 0; i < 8; i++) begin
      push(1'b1, vexp[i]);
      set1(1'b1, 16'h8421, vcnt[i], vop[i]);
      @(negedge clk);
      chk("opcov_r1", 16'(req1_ready), 16'h1);
      cyc();
    end
    set1(1'b0, 16'h0, 4'd0, 2'b00);
    repeat (2) cyc();

    // Contention: both valid 4 cycles; each port reloads after its accept.
    for (int i = 0; i < 4; i++) push(i[0], c_exp[i]);
    set0(1'b1, c_in[0], c_cnt[0], c_op[0]);
    set1(1'b1, c_in[1], c_cnt[1], c_op[1]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cont_r0", 16'(req0_ready), 16'(!i[0]));
      chk("cont_r1", 16'(req1_ready), 16'(i[0]));
      if (i > 0) chk("cont_no_bubble", 16'(res_valid), 16'h1);
      cyc();
      if (i < 2) begin
        if (i[0]) set1(1'b1, c_in[3], c_cnt[3], c_op[3]);
        else      set0(1'b1, c_in[2], c_cnt[2], c_op[2]);
      end
    end
    set0(1'b0, 16'h0, 4'd0, 2'b00);
    set1(1'b0, 16'h0, 4'd0, 2'b00);
    repeat (2) cyc();

    // Backpressure: rr=0 so port 0 wins, then 3 stalled cycles.
    res_ready = 1'b0;
    push(1'b0, 16'h1234);
    push(1'b1, 16'hFF00);
    push(1'b0, 16'hF0F0);
    set0(1'b1, 16'h1234, 4'd0, 2'b00);
    set1(1'b1, 16'h00FF, 4'd8, 2'b01);
    @(negedge clk);
    chk("bp_first_r0", 16'(req0_ready), 16'h1);
    cyc();
    set0(1'b1, 16'h0F0F, 4'd4, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_r0_low", 16'(req0_ready), 16'h0);
      chk("bp_r1_low", 16'(req1_ready), 16'h0);
      chk("bp_data_hold", res_data, 16'h1234);
      cyc();
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_r1", 16'(req1_ready), 16'h1);
    chk("bp_release_r0", 16'(req0_ready), 16'h0);
    cyc();
    set1(1'b0, 16'h0, 4'd0, 2'b00);
    @(negedge clk);
    chk("bp_next_valid", 16'(res_valid), 16'h1);
    chk("bp_next_src", 16'(res_src), 16'h1);
    cyc();
    set0(1'b0, 16'h0, 4'd0, 2'b00);
    repeat (2) cyc();

    // Idle priority hold: port-1 accept sets rr=0, idle cycles keep it.
    push(1'b1, 16'h0004);
    push(1'b0, 16'h8000);
    push(1'b1, 16'h0001);
    set1(1'b1, 16'h0002, 4'd1, 2'b00);
    @(negedge clk);
    chk("idle_p1_r1", 16'(req1_ready), 16'h1);
    cyc();
    set1(1'b0, 16'h0, 4'd0, 2'b00);
    repeat (2) cyc();
    set0(1'b1, 16'h4000, 4'd1, 2'b00);
    set1(1'b1, 16'hFFFF, 4'd15, 2'b11);
    @(negedge clk);
    chk("idle_hold_r0", 16'(req0_ready), 16'h1);
    chk("idle_hold_r1", 16'(req1_ready), 16'h0);
    cyc();
    set0(1'b0, 16'h0, 4'd0, 2'b00);
    @(negedge clk);
    chk("idle_then_r1", 16'(req1_ready), 16'h1);
    cyc();
    set1(1'b0, 16'h0, 4'd0, 2'b00);
    repeat (3) cyc();

    chk("sb_drained", 16'(exp_q.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
